// File: rtl/coin_acceptor_if.sv
// Purpose : bundles the coin sensor, hopper handshake, refund button and
//           credit/status outputs of the coin acceptor into a single bus.
// Ports   : master = coin/handshake driver (machine front panel, hopper);
//           slave  = coin_acceptor itself.
interface coin_acceptor_if;
  // Sensor and handshake inputs to the acceptor
  logic       coin_s;        // shilling sensor level
  logic       coin_f;        // florin sensor level
  logic       coin_c;        // crown sensor level
  logic       hopper_ready;  // hopper takes a payout request this cycle
  logic       cancel;        // coin-return button (REFUND_EN builds only)

  // Acceptor outputs
  logic [3:0] credit;        // credit, or change still owed, in shillings
  logic       dispense;      // vend strobe / LED
  logic       pay_florin;    // request one florin of change
  logic       pay_shilling;  // request one shilling of change
  logic       busy;          // coins are not accepted

  modport master (
    output coin_s, coin_f, coin_c, hopper_ready, cancel,
    input  credit, dispense, pay_florin, pay_shilling, busy
  );

  modport slave (
    input  coin_s, coin_f, coin_c, hopper_ready, cancel,
    output credit, dispense, pay_florin, pay_shilling, busy
  );
endinterface

// File: rtl/coin_acceptor.sv
// Purpose : vending-machine credit engine. Counts shilling/florin/crown coin
//           edges, vends when the price is reached, then pays back the
//           overpayment one coin at a time over the hopper handshake.
// Ports   : clk (rising edge), reset (async, active high), bus (slave side of
//           coin_acceptor_if: coin_s/f/c, hopper_ready, cancel in;
//           credit, dispense, pay_florin, pay_shilling, busy out).
// Build   : define REFUND_EN to let cancel refund the credit held in COLLECT;
//           without it cancel is ignored.
module coin_acceptor #(
  parameter int PRICE           = 5,  // item price in shillings, 1..11
  parameter int DISPENSE_CYCLES = 4   // dispense strobe length, 1..15
) (
  input  logic            clk,
  input  logic            reset,
  coin_acceptor_if.slave  bus
);

  // Keeping PRICE <= 11 bounds credit at 10 + 5 = 15, so 4 bits never wrap.
  if (PRICE < 1 || PRICE > 11) begin : g_bad_price
    $error("coin_acceptor: PRICE %0d outside legal range 1..11", PRICE);
  end
  if (DISPENSE_CYCLES < 1 || DISPENSE_CYCLES > 15) begin : g_bad_dispense
    $error("coin_acceptor: DISPENSE_CYCLES %0d outside legal range 1..15",
           DISPENSE_CYCLES);
  end

  localparam logic [4:0] LP_PRICE5 = 5'(PRICE);
  localparam logic [3:0] LP_PRICE4 = 4'(PRICE);
  // Counter is loaded with N-1 and the strobe drops when it reads zero,
  // giving exactly N high cycles.
  localparam logic [3:0] LP_DCNT   = 4'(DISPENSE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_credit;
  logic [3:0] r_cnt;
  logic       r_dispense;
  logic       r_hist_s;
  logic       r_hist_f;
  logic       r_hist_c;

  logic       w_ev_s;
  logic       w_ev_f;
  logic       w_ev_c;
  logic       w_any_ev;
  logic [2:0] w_val;
  logic [4:0] w_sum;
  logic [3:0] w_rem;
  logic       w_pay_f;
  logic       w_pay_s;
  logic       w_payout;
  logic [3:0] w_dec;

  // Rising-edge detect against the previous sample: a held level counts once.
  assign w_ev_s   = bus.coin_s & ~r_hist_s;
  assign w_ev_f   = bus.coin_f & ~r_hist_f;
  assign w_ev_c   = bus.coin_c & ~r_hist_c;
  assign w_any_ev = w_ev_s | w_ev_f | w_ev_c;

  // Only the most valuable coin of a simultaneous group is credited; the
  // others are dropped, not queued.
  always_comb begin
    w_val = 3'd0;
    if (w_ev_c) begin
      w_val = 3'd5;
    end else if (w_ev_f) begin
      w_val = 3'd2;
    end else if (w_ev_s) begin
      w_val = 3'd1;
    end
  end

  // One spare bit so the price comparison is exact even at the 15 ceiling.
  assign w_sum = {1'b0, r_credit} + {2'b00, w_val};
  assign w_rem = w_sum[3:0] - LP_PRICE4;

  // Florins first; a shilling only when exactly one is left, so the two
  // requests are mutually exclusive.
  assign w_pay_f  = (r_state == ST_CHANGE) && (r_credit >= 4'd2);
  assign w_pay_s  = (r_state == ST_CHANGE) && (r_credit == 4'd1);
  assign w_payout = (w_pay_f | w_pay_s) & bus.hopper_ready;
  assign w_dec    = w_pay_f ? 4'd2 : 4'd1;

`ifndef REFUND_EN
  // cancel has no function in this build.
  logic w_unused_cancel;
  assign w_unused_cancel = bus.cancel;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_COLLECT;
      r_credit   <= 4'd0;
      r_cnt      <= 4'd0;
      r_dispense <= 1'b0;
      r_hist_s   <= 1'b0;
      r_hist_f   <= 1'b0;
      r_hist_c   <= 1'b0;
    end else begin
      // History tracks the sensors in every state, so a coin held through
      // DISPENSE/CHANGE is not counted again on return to COLLECT.
      r_hist_s <= bus.coin_s;
      r_hist_f <= bus.coin_f;
      r_hist_c <= bus.coin_c;

      case (r_state)
        ST_COLLECT: begin
          if (w_any_ev) begin
            if (w_sum >= LP_PRICE5) begin
              // Overpayment is kept in credit and paid out after the vend.
              r_credit   <= w_rem;
              r_state    <= ST_DISPENSE;
              r_dispense <= 1'b1;
              r_cnt      <= LP_DCNT;
            end else begin
              r_credit <= w_sum[3:0];
            end
          end
`ifdef REFUND_EN
          // A coin edge in the same cycle wins; cancel is then ignored.
          else if (bus.cancel && (r_credit != 4'd0)) begin
            r_state <= ST_CHANGE;
          end
`endif
        end

        ST_DISPENSE: begin
          if (r_cnt == 4'd0) begin
            r_dispense <= 1'b0;
            r_state    <= (r_credit != 4'd0) ? ST_CHANGE : ST_COLLECT;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_CHANGE: begin
          // No timeout: the request simply waits for the hopper.
          if (w_payout) begin
            r_credit <= r_credit - w_dec;
            if (r_credit == w_dec) begin
              r_state <= ST_COLLECT;
            end
          end
        end

        default: begin
          r_state <= ST_COLLECT;
        end
      endcase
    end
  end

  assign bus.credit       = r_credit;
  assign bus.dispense     = r_dispense;
  assign bus.pay_florin   = w_pay_f;
  assign bus.pay_shilling = w_pay_s;
  assign bus.busy         = (r_state != ST_COLLECT);

endmodule

// File: tb/tb_coin_acceptor.sv
// Purpose : self-checking bench for coin_acceptor; a transaction-level credit
//           model fills an expectation queue that a negedge monitor drains.
// Ports   : none (drives the interface, instantiates the DUT).
// Build   : define REFUND_EN to exercise the cancel/refund path.
module tb_coin_acceptor;

  localparam int PRICE = 5;
  localparam int DC    = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coin_acceptor_if bus ();

  coin_acceptor #(
    .PRICE           (PRICE),
    .DISPENSE_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int {K_CRED, K_VEND, K_REFUND, K_PAYF, K_PAYS} kind_t;
  typedef struct {
    kind_t kind;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec        = 0;
  int   n_err        = 0;
  int   model_credit = 0;
  bit   mon_en       = 1'b0;
  int   hopper_mode  = 2;  // 0 random, 1 held low, 2 held high

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void push(input kind_t k, input int v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // Change is paid florins first, then a final shilling if odd.
  function automatic void push_change(input int amount);
    int ch;
    ch = amount;
    while (ch > 0) begin
      if (ch >= 2) begin
        push(K_PAYF, ch);
        ch -= 2;
      end else begin
        push(K_PAYS, ch);
        ch -= 1;
      end
    end
  endfunction

  // mask bit0 shilling, bit1 florin, bit2 crown; best coin of the group wins.
  function automatic void model_coin(input int mask);
    int v;
    int c;
    v = mask[2] ? 5 : (mask[1] ? 2 : 1);
    c = model_credit + v;
    if (c >= PRICE) begin
      push(K_VEND, c - PRICE);
      push_change(c - PRICE);
      model_credit = 0;
    end else begin
      model_credit = c;
      push(K_CRED, c);
    end
  endfunction

  function automatic void model_cancel();
`ifdef REFUND_EN
    if (model_credit > 0) begin
      push(K_REFUND, model_credit);
      push_change(model_credit);
      model_credit = 0;
    end
`endif
  endfunction

  function automatic void observe(input kind_t k, input int v);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d value %0d, expected none", int'(k), v);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", int'(k), int'(e.kind));
      chk("event_value", v, e.val);
    end
  endfunction

  // Monitor: turns DUT output activity into events and scores them.
  initial begin
    logic p_busy;
    int   p_credit;
    int   run;
    p_busy   = 1'b0;
    p_credit = 0;
    run      = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!p_busy && bus.busy) begin
          observe(bus.dispense ? K_VEND : K_REFUND, int'(bus.credit));
        end else if (!p_busy && !bus.busy && int'(bus.credit) != p_credit) begin
          observe(K_CRED, int'(bus.credit));
        end
        if (bus.pay_florin && bus.hopper_ready) observe(K_PAYF, int'(bus.credit));
        if (bus.pay_shilling && bus.hopper_ready) observe(K_PAYS, int'(bus.credit));
        if (bus.pay_florin && bus.pay_shilling) begin
          chk("pay_exclusive", 1, 0);
        end
        if (bus.dispense) begin
          run++;
        end else if (run > 0) begin
          chk("dispense_len", run, DC);
          run = 0;
        end
      end else begin
        run = 0;
      end
      p_busy   = bus.busy;
      p_credit = int'(bus.credit);
    end
  end

  // Hopper readiness driver.
  initial begin
    bus.hopper_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (hopper_mode)
        0:       bus.hopper_ready = 1'($urandom_range(0, 1));
        1:       bus.hopper_ready = 1'b0;
        default: bus.hopper_ready = 1'b1;
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (bus.busy && i < 200) begin
      tick();
      i++;
    end
    if (bus.busy) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, expected 0", bus.busy, i);
    end
  endtask

  task automatic wait_pay_florin();
    int i;
    i = 0;
    while (!bus.pay_florin && i < 50) begin
      tick();
      i++;
    end
    if (!bus.pay_florin) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_pay_florin: pay_florin %0d after %0d cycles, expected 1", bus.pay_florin, i);
    end
  endtask

  task automatic coin_txn(input int mask, input int hold, input bit with_cancel);
    wait_idle();
    model_coin(mask);
    bus.coin_s = mask[0];
    bus.coin_f = mask[1];
    bus.coin_c = mask[2];
    bus.cancel = with_cancel;
    tick();
    bus.cancel = 1'b0;
    repeat (hold - 1) tick();
    bus.coin_s = 1'b0;
    bus.coin_f = 1'b0;
    bus.coin_c = 1'b0;
    tick();
  endtask

  task automatic cancel_txn();
    wait_idle();
    model_cancel();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    bus.coin_s = 1'b0;
    bus.coin_f = 1'b0;
    bus.coin_c = 1'b0;
    bus.cancel = 1'b0;
    repeat (2) tick();
    chk("reset_credit", int'(bus.credit), 0);
    chk("reset_dispense", int'(bus.dispense), 0);
    chk("reset_pay_florin", int'(bus.pay_florin), 0);
    chk("reset_pay_shilling", int'(bus.pay_shilling), 0);
    chk("reset_busy", int'(bus.busy), 0);
    reset = 1'b0;
    tick();
    mon_en = 1'b1;

    // Exact price: 1 + 2 + 2.
    coin_txn(1, 1, 1'b0);
    coin_txn(2, 1, 1'b0);
    coin_txn(2, 1, 1'b0);
    wait_idle();
    chk("busy_after_exact", int'(bus.busy), 0);

    // Overpay by two: florin then crown.
    coin_txn(2, 1, 1'b0);
    coin_txn(4, 2, 1'b0);

    // Crown and florin together, held across the whole vend.
    coin_txn(6, 10, 1'b0);
    wait_idle();
    chk("credit_after_simul", int'(bus.credit), 0);

    // Change of 4 with the hopper stalled for 5 cycles.
    repeat (4) coin_txn(1, 1, 1'b0);
    hopper_mode = 1;
    coin_txn(4, 1, 1'b0);
    wait_pay_florin();
    for (int i = 0; i < 5; i++) begin
      chk("stall_pay_florin", int'(bus.pay_florin), 1);
      chk("stall_credit", int'(bus.credit), 4);
      chk("stall_pay_shilling", int'(bus.pay_shilling), 0);
      tick();
    end
    hopper_mode = 2;
    wait_idle();

    // Reset in the middle of paying out 4.
    hopper_mode = 1;
    repeat (4) coin_txn(1, 1, 1'b0);
    coin_txn(4, 1, 1'b0);
    wait_pay_florin();
    mon_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_credit", int'(bus.credit), 0);
    chk("midreset_pay_florin", int'(bus.pay_florin), 0);
    chk("midreset_pay_shilling", int'(bus.pay_shilling), 0);
    chk("midreset_dispense", int'(bus.dispense), 0);
    chk("midreset_busy", int'(bus.busy), 0);
    exp_q.delete();
    model_credit = 0;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    hopper_mode = 2;
    mon_en      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("postreset_pay", int'(bus.pay_florin | bus.pay_shilling), 0);
      chk("postreset_busy", int'(bus.busy), 0);
    end

    // Florin, shilling, cancel.
    coin_txn(2, 1, 1'b0);
    coin_txn(1, 1, 1'b0);
    cancel_txn();
    wait_idle();
`ifdef REFUND_EN
    chk("refund_credit", int'(bus.credit), 0);
`else
    chk("cancel_ignored_credit", int'(bus.credit), 3);
    chk("cancel_ignored_busy", int'(bus.busy), 0);
`endif

    // Random traffic with a random hopper.
    hopper_mode = 0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        cancel_txn();
      end else begin
        coin_txn(int'($urandom_range(1, 7)), int'($urandom_range(1, 8)),
                 ($urandom_range(0, 3) == 0));
      end
    end

    hopper_mode = 2;
    wait_idle();
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
